dp_exec: RTL

//  Datapath instruction executor: downstream consumer of AntDraw's start_dp/instruction_dp.

---
 rtl/dp_exec.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dp_exec.sv
// Datapath instruction executor: runs one NOP/PLOT/READ command per start edge and reports on finished/result.
// Optional feature macro DP_WRITE_EN: opcode 3 becomes a RAM WRITE and the mem_wr_en/mem_wdata ports appear.
module dp_exec #(
  parameter int INSTR_W    = 32,
  parameter int RESULT_W   = 16,
  parameter int MEM_ADDR_W = 16,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [INSTR_W-1:0]    instruction,
  output logic                  finished,
  output logic [RESULT_W-1:0]   result,
  output logic                  error,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [RESULT_W-1:0]   mem_rdata,
  output logic [7:0]            vga_x,
  output logic [6:0]            vga_y,
  output logic [2:0]            vga_colour,
  output logic                  vga_plot,
`ifdef DP_WRITE_EN
  output logic                  mem_wr_en,
  output logic [RESULT_W-1:0]   mem_wdata,
`endif
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EXEC_PLOT = 3'd1,
    S_READ_WAIT = 3'd2,
    S_WRITE     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PLOT = 4'd1;
  localparam logic [3:0] OP_READ = 4'd2;
`ifdef DP_WRITE_EN
  localparam logic [3:0] OP_WRITE = 4'd3;
`endif

  state_t               r_state;
  state_t               w_next;
  logic                 r_start_q;
  logic [INSTR_W-1:0]   r_instr;
  logic [2:0]           r_cnt;
  logic [RESULT_W-1:0]  r_rdata;
  logic                 r_finished;
  logic [RESULT_W-1:0]  r_result;
  logic                 r_error;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_plot;
  logic                 w_rd_en;
  logic                 w_illegal;
  logic [RESULT_W-1:0]  w_done_result;
  logic [3:0]           w_opcode;
  logic                 w_unused;
`ifdef DP_WRITE_EN
  logic                 w_wr_en;
`endif

  // Handshake: a command is taken on the first clock where start is high, was low the
  // previous clock, and the FSM is idle; finished drops on that edge and returns to 1
  // (with result/error valid) when the command completes. start while busy is ignored.
  assign w_opcode = instruction[31:28];

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_plot    = 1'b0;
    w_rd_en   = 1'b0;
`ifdef DP_WRITE_EN
    w_wr_en   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start && !r_start_q) begin
          w_accept = 1'b1;
          case (w_opcode)
            OP_PLOT:  w_next = S_EXEC_PLOT;
            OP_READ:  w_next = S_READ_WAIT;
`ifdef DP_WRITE_EN
            OP_WRITE: w_next = S_WRITE;
`endif
            default:  w_next = S_DONE;
          endcase
        end
      end
      S_EXEC_PLOT: begin
        w_plot = r_instr[18];
        w_next = S_DONE;
      end
      S_READ_WAIT: begin
        // Strobe in the first wait cycle; data lands MEM_LAT cycles later.
        w_rd_en = (r_cnt == 3'd0);
        if (r_cnt == 3'(MEM_LAT)) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
      end
`ifdef DP_WRITE_EN
      S_WRITE: begin
        w_wr_en = 1'b1;
        w_next  = S_DONE;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_illegal     = 1'b1;
    w_done_result = {RESULT_W{1'b1}};
    case (r_instr[31:28])
      OP_NOP, OP_PLOT: begin
        w_illegal     = 1'b0;
        w_done_result = '0;
      end
      OP_READ: begin
        w_illegal     = 1'b0;
        w_done_result = r_rdata;
      end
`ifdef DP_WRITE_EN
      OP_WRITE: begin
        w_illegal     = 1'b0;
        w_done_result = '0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_instr    <= '0;
      r_cnt      <= 3'd0;
      r_rdata    <= '0;
      r_finished <= 1'b1;
      r_result   <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_q <= start;
      r_cnt     <= (r_state == S_READ_WAIT) ? r_cnt + 3'd1 : 3'd0;
      if (w_accept) begin
        r_instr    <= instruction;
        r_finished <= 1'b0;
        r_error    <= 1'b0;
      end
      if (w_capture) r_rdata <= mem_rdata;
      // Results become visible together with finished on the DONE -> IDLE edge.
      if (r_state == S_DONE) begin
        r_finished <= 1'b1;
        r_result   <= w_done_result;
        r_error    <= w_illegal;
      end
    end
  end

  assign finished   = r_finished;
  assign result     = r_result;
  assign error      = r_error;
  assign mem_addr   = r_instr[MEM_ADDR_W-1:0];
  assign mem_rd_en  = w_rd_en;
  assign vga_x      = r_instr[7:0];
  assign vga_y      = r_instr[14:8];
  assign vga_colour = r_instr[17:15];
  assign vga_plot   = w_plot;
  assign dbg_state  = r_state;
`ifdef DP_WRITE_EN
  assign mem_wr_en  = w_wr_en;
  assign mem_wdata  = {{(RESULT_W-12){1'b0}}, r_instr[27:16]};
`endif

  // Bits 27:19 carry no meaning unless the write feature is built in.
  assign w_unused = ^r_instr[27:19];

endmodule
